// File: rtl/nrzi_frame_decoder.sv
// Toggle-encoded line receiver: recovers bits by XOR of successive line levels,
// hunts for a sync word, then delivers FRAME_WORDS words over a one-deep valid/ready buffer.
module nrzi_frame_decoder #(
  parameter int unsigned       DATA_W      = 8,
  parameter logic [DATA_W-1:0] SYNC_WORD   = 8'h7E,
  parameter int unsigned       FRAME_WORDS = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              line_in,
  input  logic              in_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              in_sync,
  output logic              frame_done,
  output logic              overflow
);

  localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int unsigned WC_W  = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(DATA_W - 1);
  localparam logic [WC_W-1:0]  WORD_LAST = WC_W'(FRAME_WORDS - 1);

  typedef enum logic {HUNT, DATA} state_t;

  state_t            state, state_nxt;
  logic              prev_line;
  logic [DATA_W-1:0] sync_sr, data_sr;
  logic [CNT_W-1:0]  bit_cnt;
  logic [WC_W-1:0]   word_cnt;

  logic              dec_bit;
  logic [DATA_W-1:0] sync_nxt, word_nxt;
  logic              sync_hit, word_done, frame_end;

  assign dec_bit   = line_in ^ prev_line;
  assign sync_nxt  = {sync_sr[DATA_W-2:0], dec_bit};
  assign word_nxt  = {dec_bit, data_sr[DATA_W-1:1]};
  assign sync_hit  = (state == HUNT) && in_valid && (sync_nxt == SYNC_WORD);
  assign word_done = (state == DATA) && in_valid && (bit_cnt == BIT_LAST);
  assign frame_end = word_done && (word_cnt == WORD_LAST);

  always_ff @(posedge clk) begin
    if (rst) state <= HUNT;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      HUNT: if (sync_hit)  state_nxt = DATA;
      DATA: if (frame_end) state_nxt = HUNT;
      default: state_nxt = HUNT;
    endcase
  end

  always_comb begin
    in_sync = (state == DATA);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_line <= 1'b0;
      sync_sr   <= '0;
      data_sr   <= '0;
      bit_cnt   <= '0;
      word_cnt  <= '0;
    end else if (in_valid) begin
      prev_line <= line_in;
      if (state == HUNT) begin
        // Shifter is cleared on a hit so the next hunt starts from a clean history.
        sync_sr <= sync_hit ? '0 : sync_nxt;
        if (sync_hit) begin
          bit_cnt  <= '0;
          word_cnt <= '0;
        end
      end else begin
        data_sr <= word_nxt;
        bit_cnt <= (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
        if (word_done) word_cnt <= word_cnt + 1'b1;
      end
    end
  end

  // One holding register: a word completing against a stalled output is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data   <= '0;
      out_valid  <= 1'b0;
      overflow   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= frame_end;
      if (word_done) begin
        if (!out_valid || out_ready) begin
          out_data  <= word_nxt;
          out_valid <= 1'b1;
        end else begin
          overflow <= 1'b1;
        end
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_nrzi_frame_decoder.sv
// Bench for nrzi_frame_decoder: directed scenarios plus random traffic, all checked
// against a queue-based model of the decoded bit stream.
module tb_nrzi_frame_decoder;

  logic       clk = 1'b0;
  logic       rst, line_in, in_valid, out_ready;
  logic [7:0] out_data, o3_data;
  logic       out_valid, in_sync, frame_done, overflow;
  logic       o3_valid, o3_sync, o3_fd, o3_ovf;

  int total = 0;
  int bad   = 0;

  localparam logic [7:0] SYNC = 8'h7E;
  localparam int M_FW = 2;

  always #5 clk = ~clk;

  nrzi_frame_decoder dut (
    .clk(clk), .rst(rst), .line_in(line_in), .in_valid(in_valid),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .in_sync(in_sync), .frame_done(frame_done), .overflow(overflow)
  );

  nrzi_frame_decoder #(.DATA_W(8), .SYNC_WORD(8'h7E), .FRAME_WORDS(3)) dut3 (
    .clk(clk), .rst(rst), .line_in(line_in), .in_valid(in_valid),
    .out_data(o3_data), .out_valid(o3_valid), .out_ready(out_ready),
    .in_sync(o3_sync), .frame_done(o3_fd), .overflow(o3_ovf)
  );

  // Reference model state (for the FRAME_WORDS=2 instance)
  bit         m_prev, m_lock, m_valid, m_ovf, m_fd;
  bit         hist[$];
  bit         wbits[$];
  int         m_wcnt;
  logic [7:0] m_data;
  bit         tb_line;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_edge(input bit r, input bit l, input bit v, input bit rdy);
    bit   b, done, xfer;
    int   acc;
    logic [7:0] hv;
    if (r) begin
      m_prev = 0; m_lock = 0; m_valid = 0; m_ovf = 0; m_fd = 0;
      hist.delete(); wbits.delete(); m_wcnt = 0; m_data = 8'h00;
      return;
    end
    m_fd = 0;
    done = 0;
    acc  = 0;
    xfer = m_valid && rdy;
    if (v) begin
      b = l ^ m_prev;
      m_prev = l;
      if (!m_lock) begin
        hist.push_back(b);
        if (hist.size() > 8) void'(hist.pop_front());
        hv = 8'h00;
        foreach (hist[i]) hv = {hv[6:0], hist[i]};
        if (hv == SYNC) begin
          m_lock = 1; hist.delete(); wbits.delete(); m_wcnt = 0;
        end
      end else begin
        wbits.push_back(b);
        if (wbits.size() == 8) begin
          foreach (wbits[i]) acc += int'(wbits[i]) * (1 << i);
          wbits.delete();
          done = 1;
          m_wcnt++;
          if (m_wcnt == M_FW) begin
            m_lock = 0; m_wcnt = 0; m_fd = 1;
          end
        end
      end
    end
    if (done) begin
      if (!m_valid || rdy) begin m_data = 8'(acc); m_valid = 1; end
      else m_ovf = 1;
    end else if (xfer) begin
      m_valid = 0;
    end
  endtask

  task automatic step(input bit r, input bit l, input bit v, input bit rdy);
    rst = r; line_in = l; in_valid = v; out_ready = rdy;
    @(posedge clk);
    model_edge(r, l, v, rdy);
    #1;
    check("out_valid",  out_valid,  m_valid);
    check("out_data",   out_data,   m_data);
    check("in_sync",    in_sync,    m_lock);
    check("frame_done", frame_done, m_fd);
    check("overflow",   overflow,   m_ovf);
  endtask

  task automatic send_bit(input bit b, input bit rdy, input int gap);
    for (int g = 0; g < gap; g++) step(1'b0, 1'($urandom), 1'b0, rdy);
    tb_line ^= b;
    step(1'b0, tb_line, 1'b1, rdy);
  endtask

  task automatic send_byte(input logic [7:0] val, input bit rdy, input int gap);
    for (int i = 0; i < 8; i++) send_bit(val[i], rdy, gap);
  endtask

  task automatic send_msb(input logic [7:0] val, input bit rdy, input int gap);
    for (int i = 7; i >= 0; i--) send_bit(val[i], rdy, gap);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'(i % 2), 1'b1, 1'b1);
    tb_line = 0;
  endtask

  task automatic idle(input bit rdy);
    step(1'b0, tb_line, 1'b0, rdy);
  endtask

  initial begin
    logic [7:0] w;
    rst = 1; line_in = 0; in_valid = 0; out_ready = 1; tb_line = 0;

    // 1: reset with toggling line, outputs cleared
    do_reset(2);
    check("rst_valid", out_valid, 1'b0);
    check("rst_data", out_data, 8'h00);
    check("rst_sync", in_sync, 1'b0);
    check("rst_fd", frame_done, 1'b0);
    check("rst_ovf", overflow, 1'b0);
    // first strobe with line=1 must decode as 1: bits 1,1,1,1,1,1,0 reach 0x7E
    send_bit(1'b1, 1'b1, 0);
    for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b1, 0);
    send_bit(1'b0, 1'b1, 0);
    check("t1_first_bit_one", in_sync, 1'b1);
    do_reset(1);

    // 2: basic frame
    send_msb(SYNC, 1'b1, 0);
    check("t2_sync", in_sync, 1'b1);
    send_byte(8'hA5, 1'b1, 0);
    check("t2_w0", out_data, 8'hA5);
    check("t2_w0_v", out_valid, 1'b1);
    send_byte(8'h3C, 1'b1, 0);
    check("t2_w1", out_data, 8'h3C);
    check("t2_fd", frame_done, 1'b1);
    check("t2_unsync", in_sync, 1'b0);
    idle(1'b1);

    // 3: gapped strobes
    send_msb(SYNC, 1'b1, 2);
    send_byte(8'hA5, 1'b1, 2);
    check("t3_w0", out_data, 8'hA5);
    send_byte(8'h3C, 1'b1, 2);
    check("t3_w1", out_data, 8'h3C);
    check("t3_fd", frame_done, 1'b1);
    idle(1'b1);

    // completion coinciding with a transfer: no bubble, no overflow
    send_msb(SYNC, 1'b0, 0);
    send_byte(8'hA5, 1'b0, 0);
    w = 8'h3C;
    for (int i = 0; i < 7; i++) send_bit(w[i], 1'b0, 0);
    send_bit(w[7], 1'b1, 0);
    check("tx_same_data", out_data, 8'h3C);
    check("tx_same_valid", out_valid, 1'b1);
    check("tx_same_ovf", overflow, 1'b0);
    idle(1'b1);

    // 4: backpressure
    send_msb(SYNC, 1'b0, 0);
    send_byte(8'hA5, 1'b0, 0);
    send_byte(8'h3C, 1'b0, 0);
    check("t4_hold", out_data, 8'hA5);
    check("t4_valid", out_valid, 1'b1);
    check("t4_ovf", overflow, 1'b1);
    check("t4_fd", frame_done, 1'b1);
    idle(1'b1);
    check("t4_drain", out_valid, 1'b0);
    check("t4_ovf_sticky", overflow, 1'b1);

    // 5: three-word frame on the FRAME_WORDS=3 instance
    do_reset(1);
    send_msb(SYNC, 1'b1, 0);
    send_byte(8'h01, 1'b1, 0);
    check("t5_w0", o3_data, 8'h01);
    check("t5_w0_v", o3_valid, 1'b1);
    check("t5_w0_sync", o3_sync, 1'b1);
    check("t5_w0_fd", o3_fd, 1'b0);
    send_byte(8'h80, 1'b1, 0);
    check("t5_w1", o3_data, 8'h80);
    send_byte(8'hFF, 1'b1, 0);
    check("t5_w2", o3_data, 8'hFF);
    check("t5_fd", o3_fd, 1'b1);
    check("t5_unsync", o3_sync, 1'b0);
    check("t5_ovf", o3_ovf, 1'b0);
    idle(1'b1);
    check("t5_drain", o3_valid, 1'b0);

    // 6: robustness
    do_reset(1);
    send_msb(8'h7F, 1'b1, 0);
    send_msb(8'h3E, 1'b1, 0);
    check("t6_nolock", in_sync, 1'b0);
    for (int i = 0; i < 40; i++) send_bit(1'b0, 1'b1, 0);
    check("t6_idle", in_sync, 1'b0);
    send_msb(SYNC, 1'b1, 0);
    for (int i = 0; i < 4; i++) send_bit(1'($urandom), 1'b1, 0);
    do_reset(1);
    check("t6_rst_sync", in_sync, 1'b0);
    send_msb(SYNC, 1'b1, 0);
    send_byte(8'h5A, 1'b1, 0);
    check("t6_fresh", out_data, 8'h5A);
    send_byte(8'(($urandom)), 1'b1, 0);
    idle(1'b1);

    // random traffic: noise, sync, random words, random gaps and backpressure
    do_reset(1);
    for (int f = 0; f < 6; f++) begin
      for (int i = 0; i < 12; i++) send_bit(1'($urandom), 1'($urandom), $urandom_range(0, 2));
      send_msb(SYNC, 1'($urandom), 0);
      for (int k = 0; k < M_FW; k++) begin
        w = 8'($urandom);
        for (int i = 0; i < 8; i++) send_bit(w[i], 1'($urandom), $urandom_range(0, 2));
      end
      for (int i = 0; i < 3; i++) idle(1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
